// File: rtl/nclus_readout_arbiter_if.sv
// Request/grant/read-port bundle between the channel simulators, the readout arbiter and the FIFO side.
interface nclus_readout_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
);
    logic              in_live;
    logic              user_ena;
    logic [3:0]        user_nwords;
    logic [NREQ-1:0]   in_req;
    logic [NREQ-1:0]   out_gnt;
    logic              out_rena;
    logic [ADDR_W-1:0] out_raddr;
    logic              out_busy;
    logic [CNT_W-1:0]  out_drop_cnt;

    modport master (
        output in_live, user_ena, user_nwords, in_req,
        input  out_gnt, out_rena, out_raddr, out_busy, out_drop_cnt
    );

    modport slave (
        input  in_live, user_ena, user_nwords, in_req,
        output out_gnt, out_rena, out_raddr, out_busy, out_drop_cnt
    );
endinterface

// File: rtl/nclus_readout_arbiter.sv
// Round-robin arbiter that bursts reads from one channel's cluster-buffer region at a time.
// Define NCLUS_ARB_FIXED_PRIO_EN to select the lowest pending channel instead of round-robin.
module nclus_readout_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    nclus_readout_arbiter_if.slave bus
);
    localparam int SEL_W = $clog2(NREQ);
    localparam int PTR_W = ADDR_W - SEL_W;

    typedef enum logic [1:0] {IDLE, GRANT, BURST, GAP} state_t;

    state_t            state, state_nxt;
    logic [NREQ-1:0]   pending, clr, drops;
    logic [PTR_W-1:0]  ptr [NREQ];
    logic [SEL_W-1:0]  sel, sel_nxt, rr_last;
    logic [3:0]        nw, cnt;
    logic [NREQ-1:0]   gnt, gnt_nxt;
    logic              rena, rena_nxt, issue;
    logic [ADDR_W-1:0] raddr;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W:0]    drop_sum;

    always_comb begin
        sel_nxt = sel;
`ifdef NCLUS_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending[i]) sel_nxt = SEL_W'(i);
        end
`else
        // Scan downwards so the nearest pending channel after rr_last is assigned last.
        for (int k = NREQ; k >= 1; k--) begin
            if (pending[rr_last + SEL_W'(k)]) sel_nxt = rr_last + SEL_W'(k);
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rena_nxt  = 1'b0;
        issue     = 1'b0;
        clr       = '0;
        case (state)
            IDLE: begin
                if (bus.user_ena && (|pending)) begin
                    state_nxt = GRANT;
                    gnt_nxt   = NREQ'(1) << sel_nxt;
                end
            end
            GRANT: begin
                clr[sel] = 1'b1;
                if (bus.user_nwords == 4'd0) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                end else begin
                    state_nxt = BURST;
                    rena_nxt  = 1'b1;
                    issue     = 1'b1;
                end
            end
            BURST: begin
                if (cnt == nw) begin
                    state_nxt = GAP;
                    gnt_nxt   = '0;
                end else begin
                    rena_nxt = 1'b1;
                    issue    = 1'b1;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A request landing on an already-pending, not-being-served channel is lost.
    assign drops    = bus.in_req & pending & ~clr;
    assign drop_sum = {1'b0, drop_cnt} + (CNT_W + 1)'($countones(drops));

    always_ff @(posedge clk) begin
        if (rst || !bus.in_live) state <= IDLE;
        else                     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.in_live) begin
            pending <= '0;
            rr_last <= SEL_W'(NREQ - 1);
            gnt     <= '0;
            rena    <= 1'b0;
            raddr   <= '1;
            sel     <= '0;
            nw      <= '0;
            cnt     <= '0;
            if (rst) begin
                drop_cnt <= '0;
                for (int i = 0; i < NREQ; i++) ptr[i] <= '0;
            end
        end else begin
            pending  <= bus.in_req | (pending & ~clr);
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            gnt      <= gnt_nxt;
            rena     <= rena_nxt;
            if (state == IDLE) sel <= sel_nxt;
            if (state == GRANT) begin
                nw      <= bus.user_nwords;
                rr_last <= sel;
            end
            // Reads are registered, so each one is launched the cycle before it appears.
            if (issue) begin
                raddr    <= {sel, ptr[sel]};
                ptr[sel] <= ptr[sel] + PTR_W'(1);
                cnt      <= (state == GRANT) ? 4'd1 : cnt + 4'd1;
            end
        end
    end

    assign bus.out_gnt      = gnt;
    assign bus.out_rena     = rena;
    assign bus.out_raddr    = raddr;
    assign bus.out_busy     = (state != IDLE);
    assign bus.out_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_nclus_readout_arbiter.sv
// Bench for nclus_readout_arbiter: fixed vector table, directed corner sequences, and random
// traffic checked against a transaction-timeline model of the arbiter.
module tb_nclus_readout_arbiter;
    localparam int NREQ     = 4;
    localparam int ADDR_W   = 12;
    localparam int CNT_W    = 16;
    localparam int PTR_W    = ADDR_W - $clog2(NREQ);
    localparam int PTR_SPAN = 1 << PTR_W;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    nclus_readout_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    nclus_readout_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic             cur_ena = 1'b1;
    logic [3:0]       cur_nw  = 4'd0;
    logic [NREQ-1:0]  prev_gnt = '0;
    logic [NREQ-1:0]  gnt_log [$];
    logic [ADDR_W-1:0] addr_q [$];

    // Model: a transaction is a grant cycle (ofs 0), nw read cycles, then one gap cycle.
    logic [NREQ-1:0]   m_pend = '0;
    int                m_ptr [NREQ];
    int                m_last = NREQ - 1;
    int                m_drop = 0;
    int                m_ofs = 0;
    int                m_sel = 0;
    int                m_nw = 0;
    bit                m_active = 1'b0;
    logic [NREQ-1:0]   e_gnt = '0;
    logic              e_rena = 1'b0;
    logic [ADDR_W-1:0] e_raddr = '1;
    logic              e_busy = 1'b0;

    typedef struct {
        logic              rst;
        logic [NREQ-1:0]   req;
        logic [3:0]        nw;
        logic [NREQ-1:0]   gnt;
        logic              rena;
        logic [ADDR_W-1:0] raddr;
        logic              busy;
    } vec_t;

    vec_t vecs [$];

    task automatic addVec(input logic r, input logic [NREQ-1:0] q, input logic [3:0] n,
                          input logic [NREQ-1:0] g, input logic e, input int a, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.nw = n; v.gnt = g; v.rena = e; v.raddr = ADDR_W'(a); v.busy = b;
        vecs.push_back(v);
    endtask

    function automatic int pickChannel();
`ifdef NCLUS_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (m_pend[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (m_pend[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic modelStep(input logic r, input logic live, input logic ena,
                             input logic [3:0] nw, input logic [NREQ-1:0] req);
        int pick;
        int clr;
        if (r || !live) begin
            m_pend = '0; m_last = NREQ - 1; m_active = 1'b0;
            e_gnt = '0; e_rena = 1'b0; e_raddr = '1; e_busy = 1'b0;
            if (r) begin
                m_drop = 0;
                for (int i = 0; i < NREQ; i++) m_ptr[i] = 0;
            end
        end else begin
            pick = pickChannel();
            clr  = (m_active && m_ofs == 0) ? m_sel : -1;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (m_pend[i] && clr != i && m_drop < CNT_MAX) m_drop++;
                    m_pend[i] = 1'b1;
                end else if (clr == i) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (m_active) begin
                if (m_ofs == 0) begin
                    m_nw = int'(nw);
                    m_last = m_sel;
                end
                m_ofs++;
                if (m_ofs > m_nw + 1) m_active = 1'b0;
            end else if (ena && pick >= 0) begin
                m_active = 1'b1; m_sel = pick; m_ofs = 0;
            end
            e_busy = m_active;
            e_gnt  = (m_active && (m_ofs == 0 || m_ofs <= m_nw)) ? (NREQ'(1) << m_sel) : '0;
            e_rena = m_active && m_ofs >= 1 && m_ofs <= m_nw;
            if (e_rena) begin
                e_raddr = ADDR_W'(m_sel * PTR_SPAN + m_ptr[m_sel]);
                m_ptr[m_sel] = (m_ptr[m_sel] + 1) % PTR_SPAN;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic live, input logic ena,
                                 input logic [3:0] nw, input logic [NREQ-1:0] req);
        rst = r;
        bus.in_live = live; bus.user_ena = ena; bus.user_nwords = nw; bus.in_req = req;
        @(posedge clk);
        modelStep(r, live, ena, nw, req);
        #1;
        if (bus.out_gnt != '0 && prev_gnt == '0) gnt_log.push_back(bus.out_gnt);
        prev_gnt = bus.out_gnt;
    endtask

    task automatic step(input logic [NREQ-1:0] req);
        applyStimulus(1'b0, 1'b1, cur_ena, cur_nw, req);
    endtask

    task automatic doBurst(input int ch, input logic [3:0] n);
        bit seen;
        bit done;
        seen = 1'b0; done = 1'b0;
        addr_q.delete();
        cur_nw = n;
        step(NREQ'(1) << ch);
        for (int c = 0; c < 40; c++) begin
            if (bus.out_busy) seen = 1'b1;
            if (bus.out_rena) addr_q.push_back(bus.out_raddr);
            if (seen && !bus.out_busy) begin
                done = 1'b1;
                break;
            end
            step('0);
        end
        checkOutput("burst completes in budget", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int nr;
        int prev;
        int n1;
        logic [NREQ-1:0] exp_g;
        logic rr, lv, en;
        logic [3:0] nwr;
        logic [NREQ-1:0] rq;

        rst = 1'b1;
        bus.in_live = 1'b1; bus.user_ena = 1'b1; bus.user_nwords = '0; bus.in_req = '0;

        // Single-channel burst straight out of reset, three words.
        addVec(1, 4'b0000, 3, 4'b0000, 0, 'hFFF, 0);
        addVec(0, 4'b0001, 3, 4'b0000, 0, 'hFFF, 0);
        addVec(0, 4'b0000, 3, 4'b0001, 0, 'hFFF, 1);
        addVec(0, 4'b0000, 3, 4'b0001, 1, 'h000, 1);
        addVec(0, 4'b0000, 3, 4'b0001, 1, 'h001, 1);
        addVec(0, 4'b0000, 3, 4'b0001, 1, 'h002, 1);
        addVec(0, 4'b0000, 3, 4'b0000, 0, 'h002, 1);
        addVec(0, 4'b0000, 3, 4'b0000, 0, 'h002, 0);
        // All four channels requesting at once, two words each, served 0..3.
        addVec(1, 4'b0000, 2, 4'b0000, 0, 'hFFF, 0);
        addVec(0, 4'b1111, 2, 4'b0000, 0, 'hFFF, 0);
        prev = 'hFFF;
        for (int ch = 0; ch < NREQ; ch++) begin
            addVec(0, 4'b0000, 2, NREQ'(1) << ch, 0, prev, 1);
            addVec(0, 4'b0000, 2, NREQ'(1) << ch, 1, ch * PTR_SPAN, 1);
            addVec(0, 4'b0000, 2, NREQ'(1) << ch, 1, ch * PTR_SPAN + 1, 1);
            prev = ch * PTR_SPAN + 1;
            addVec(0, 4'b0000, 2, 4'b0000, 0, prev, 1);
            addVec(0, 4'b0000, 2, 4'b0000, 0, prev, 0);
        end

        $display("[TB] table vectors: %0d", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, 1'b1, 1'b1, vecs[i].nw, vecs[i].req);
            checkOutput($sformatf("vec%0d gnt", i),   32'(bus.out_gnt),   32'(vecs[i].gnt));
            checkOutput($sformatf("vec%0d rena", i),  32'(bus.out_rena),  32'(vecs[i].rena));
            checkOutput($sformatf("vec%0d raddr", i), 32'(bus.out_raddr), 32'(vecs[i].raddr));
            checkOutput($sformatf("vec%0d busy", i),  32'(bus.out_busy),  32'(vecs[i].busy));
            if (i == 0) checkOutput("reset drop_cnt", 32'(bus.out_drop_cnt), 32'd0);
        end

        $display("[TB] overlapping request on a pending channel");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd4, '0);
        cur_ena = 1'b1; cur_nw = 4'd4;
        gnt_log.delete();
        step(4'b0010); step('0); step('0);
        step(4'b0010); step('0); step(4'b0010);
        checkOutput("drop after overlap", 32'(bus.out_drop_cnt), 32'd1);
        for (int c = 0; c < 40; c++) step('0);
        n1 = 0;
        foreach (gnt_log[i]) if (gnt_log[i] == 4'b0010) n1++;
        checkOutput("ch1 served twice", 32'(n1), 32'd2);
        checkOutput("drop stays at one", 32'(bus.out_drop_cnt), 32'd1);

        $display("[TB] pointer wrap on ch0");
        for (int b = 0; b < 68; b++) doBurst(0, 4'd15);
        doBurst(0, 4'd3);
        doBurst(0, 4'd2);
        checkOutput("wrap read count", 32'(addr_q.size()), 32'd2);
        if (addr_q.size() >= 2) begin
            checkOutput("wrap first addr", 32'(addr_q[0]), 32'h3FF);
            checkOutput("wrap second addr", 32'(addr_q[1]), 32'h000);
        end

        $display("[TB] abort mid-burst and zero-word grant");
        cur_nw = 4'd8;
        step(4'b0100);
        nr = 0;
        for (int c = 0; c < 20 && nr < 3; c++) begin
            step('0);
            if (bus.out_rena) nr++;
        end
        checkOutput("abort reached burst", 32'(nr), 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd8, '0);
        checkOutput("abort gnt", 32'(bus.out_gnt), 32'd0);
        checkOutput("abort rena", 32'(bus.out_rena), 32'd0);
        checkOutput("abort raddr", 32'(bus.out_raddr), 32'hFFF);
        checkOutput("abort busy", 32'(bus.out_busy), 32'd0);
        checkOutput("abort drop held", 32'(bus.out_drop_cnt), 32'd1);
        gnt_log.delete();
        doBurst(3, 4'd0);
        checkOutput("nw0 read count", 32'(addr_q.size()), 32'd0);
        checkOutput("nw0 grant count", 32'(gnt_log.size()), 32'd1);

        $display("[TB] repeated requests on ch1 and ch3");
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1, '0);
        cur_nw = 4'd1;
        gnt_log.delete();
        for (int c = 0; c < 80 && gnt_log.size() < 4; c++) step(4'b1010);
        checkOutput("prio grant count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < gnt_log.size() && i < 4; i++) begin
`ifdef NCLUS_ARB_FIXED_PRIO_EN
            exp_g = 4'b0010;
`else
            exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            checkOutput($sformatf("grant order %0d", i), 32'(gnt_log[i]), 32'(exp_g));
        end
        for (int c = 0; c < 30; c++) step('0);

        $display("[TB] random traffic against model");
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, '0);
        for (int c = 0; c < 3000; c++) begin
            rr  = ($urandom_range(0, 499) == 0);
            lv  = ($urandom_range(0, 149) != 0);
            en  = ($urandom_range(0, 9) != 0);
            nwr = 4'($urandom_range(0, 5));
            for (int i = 0; i < NREQ; i++) rq[i] = ($urandom_range(0, 5) == 0);
            applyStimulus(rr, lv, en, nwr, rq);
            checkOutput($sformatf("rnd%0d gnt", c),   32'(bus.out_gnt),      32'(e_gnt));
            checkOutput($sformatf("rnd%0d rena", c),  32'(bus.out_rena),     32'(e_rena));
            checkOutput($sformatf("rnd%0d raddr", c), 32'(bus.out_raddr),    32'(e_raddr));
            checkOutput($sformatf("rnd%0d busy", c),  32'(bus.out_busy),     32'(e_busy));
            checkOutput($sformatf("rnd%0d drop", c),  32'(bus.out_drop_cnt), 32'(m_drop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
